// File: rtl/shift_pipe_unit_if.sv
// Handshake bundle for shift_pipe_unit: issue side (in_*) and writeback side (out_*).
// The slave modport is the shifter's view; master is the surrounding pipeline's view.
interface shift_pipe_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_op;
  logic [4:0]  in_tag;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_pipe_unit.sv
// Two-stage pipelined 32-bit barrel shifter (SLL / SRA, 0..31 positions) with
// valid/ready on both sides and a synchronous flush for branch mispredicts.
module shift_pipe_unit (
  input logic              clock,
  input logic              reset,
  input logic              flush,
  shift_pipe_unit_if.slave bus
);

  typedef enum logic {
    OP_SLL = 1'b0,
    OP_SRA = 1'b1
  } shift_op_e;

  // One barrel level: shift by a fixed amount when enabled; right shifts
  // back-fill the vacated upper bits with the supplied fill bit.
  function automatic logic [31:0] sub_shift(
    input logic [31:0] d,
    input logic        en,
    input logic        is_sra,
    input logic        fill,
    input logic [4:0]  amt
  );
    logic [31:0] fill_mask;
    fill_mask = ~(32'hFFFF_FFFF >> amt);
    if (!en)
      sub_shift = d;
    else if (is_sra)
      sub_shift = (d >> amt) | (fill ? fill_mask : 32'h0);
    else
      sub_shift = d << amt;
  endfunction

  // Stage A state
  logic        r_va;
  logic [31:0] r_data_a;
  logic [2:0]  r_shamt_a;
  shift_op_e   r_op_a;
  logic        r_sign_a;
  logic [4:0]  r_tag_a;

  // Stage B state
  logic        r_vb;
  logic [31:0] r_data_b;
  logic [4:0]  r_tag_b;

  logic        w_ready_a;
  logic        w_ready_b;
  logic        w_in_sra;
  logic        w_a_sra;
  logic [31:0] w_a_s16;
  logic [31:0] w_a_s8;
  logic [31:0] w_b_s4;
  logic [31:0] w_b_s2;
  logic [31:0] w_b_s1;

  assign w_ready_b = !r_vb || bus.out_ready;
  assign w_ready_a = !r_va || w_ready_b;

  assign w_in_sra = (shift_op_e'(bus.in_op) == OP_SRA);
  assign w_a_sra  = (r_op_a == OP_SRA);

  always_comb begin
    w_a_s16 = sub_shift(bus.in_data, bus.in_shamt[4], w_in_sra, bus.in_data[31], 5'd16);
    w_a_s8  = sub_shift(w_a_s16,     bus.in_shamt[3], w_in_sra, bus.in_data[31], 5'd8);
  end

  // Stage B only sees registered stage-A values, so in_* never reaches out_*.
  always_comb begin
    w_b_s4 = sub_shift(r_data_a, r_shamt_a[2], w_a_sra, r_sign_a, 5'd4);
    w_b_s2 = sub_shift(w_b_s4,   r_shamt_a[1], w_a_sra, r_sign_a, 5'd2);
    w_b_s1 = sub_shift(w_b_s2,   r_shamt_a[0], w_a_sra, r_sign_a, 5'd1);
  end

  // NOTE: every register here uses <= so all stages sample the pre-edge values
  // of their neighbours; blocking assignments would let an op skip a stage.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the data registers are reset as well as the valids so out_data and
    // out_tag read zero after reset instead of leftover operands.
    if (reset) begin
      r_va      <= 1'b0;
      r_data_a  <= '0;
      r_shamt_a <= '0;
      r_op_a    <= OP_SLL;
      r_sign_a  <= 1'b0;
      r_tag_a   <= '0;
    end else if (flush) begin
      r_va <= 1'b0;
    end else if (w_ready_a) begin
      r_va <= bus.in_valid;
      if (bus.in_valid) begin
        r_data_a  <= w_a_s8;
        r_shamt_a <= bus.in_shamt[2:0];
        r_op_a    <= shift_op_e'(bus.in_op);
        r_sign_a  <= bus.in_data[31];
        r_tag_a   <= bus.in_tag;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vb     <= 1'b0;
      r_data_b <= '0;
      r_tag_b  <= '0;
    end else if (flush) begin
      r_vb <= 1'b0;
    end else if (w_ready_b) begin
      r_vb <= r_va;
      if (r_va) begin
        r_data_b <= w_b_s1;
        r_tag_b  <= r_tag_a;
      end
    end
  end

  assign bus.in_ready  = w_ready_a;
  assign bus.out_valid = r_vb;
  assign bus.out_data  = r_data_b;
  assign bus.out_tag   = r_tag_b;

endmodule
